// File: rtl/sync_prefetch_fifo_flex_if.sv
// Handshake bundle for sync_prefetch_fifo_flex: write port, prefetched read port, status flags.
// FIFO_ERR_STATS_EN adds the sticky error flags and their clear input.
interface sync_prefetch_fifo_flex_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11
);
    logic                   flush;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_vld;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_vld;
    logic [DEPTH_WIDTH:0]   count;
    logic                   almost_full;
    logic                   almost_empty;
`ifdef FIFO_ERR_STATS_EN
    logic                   ovf_err;
    logic                   udf_err;
    logic                   err_clr;
`endif

    modport master (
        output flush, wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_STATS_EN
        output err_clr,
        input  ovf_err, udf_err,
`endif
        input  wr_vld, rd_data, rd_vld, count, almost_full, almost_empty
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_STATS_EN
        input  err_clr,
        output ovf_err, udf_err,
`endif
        output wr_vld, rd_data, rd_vld, count, almost_full, almost_empty
    );
endinterface

// File: rtl/sync_prefetch_fifo_flex.sv
// Single-clock first-word-fall-through FIFO: (2^DEPTH_WIDTH-1)-word RAM plus one prefetch register.
// Optional FIFO_ERR_STATS_EN adds sticky overflow/underflow flags with err_clr.
module sync_prefetch_fifo_flex #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11,
    parameter int AFULL_TH    = 2**DEPTH_WIDTH - 4,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sync_prefetch_fifo_flex_if.slave bus
);
    localparam int                     RAM_DEPTH  = 2**DEPTH_WIDTH - 1;
    localparam logic [DEPTH_WIDTH-1:0] PTR_LAST   = (DEPTH_WIDTH)'(RAM_DEPTH - 1);
    localparam logic [DEPTH_WIDTH:0]   CAPACITY   = (DEPTH_WIDTH+1)'(2**DEPTH_WIDTH);
    localparam logic [DEPTH_WIDTH:0]   AFULL_LVL  = (DEPTH_WIDTH+1)'(AFULL_TH);
    localparam logic [DEPTH_WIDTH:0]   AEMPTY_LVL = (DEPTH_WIDTH+1)'(AEMPTY_TH);
    localparam logic [DEPTH_WIDTH:0]   ONE        = (DEPTH_WIDTH+1)'(1);

    typedef enum logic {S_EMPTY, S_VALID} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   ram [RAM_DEPTH];
    logic [DEPTH_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_WIDTH:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0]   head_q;
    logic                    wr_vld_q, afull_q, aempty_q;
    logic                    wr_acc, rd_acc, ram_empty;
    logic                    ram_wr, ram_rd, load_from_wr;

    function automatic logic [DEPTH_WIDTH-1:0] ptr_inc(input logic [DEPTH_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_acc    = bus.wr_en && wr_vld_q;
    assign rd_acc    = bus.rd_en && (state_q == S_VALID);
    // The head word lives in the output register, so the RAM is empty whenever count <= 1.
    assign ram_empty = (count_q <= ONE);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d      = state_q;
        ram_wr       = 1'b0;
        ram_rd       = 1'b0;
        load_from_wr = 1'b0;
        count_d      = count_q;
        case (state_q)
            S_EMPTY: begin
                if (wr_acc) begin
                    load_from_wr = 1'b1;
                    state_d      = S_VALID;
                end
            end
            S_VALID: begin
                if (rd_acc && !ram_empty) begin
                    ram_rd = 1'b1;
                    ram_wr = wr_acc;
                end else if (rd_acc) begin
                    if (wr_acc) load_from_wr = 1'b1;
                    else        state_d      = S_EMPTY;
                end else begin
                    ram_wr = wr_acc;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (wr_acc && !rd_acc)      count_d = count_q + ONE;
        else if (rd_acc && !wr_acc) count_d = count_q - ONE;
        if (bus.flush) begin
            state_d      = S_EMPTY;
            ram_wr       = 1'b0;
            ram_rd       = 1'b0;
            load_from_wr = 1'b0;
            count_d      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            head_q   <= '0;
            wr_vld_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_vld_q <= (count_d < CAPACITY);
            afull_q  <= (count_d >= AFULL_LVL);
            aempty_q <= (count_d <= AEMPTY_LVL);
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
                if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
            end
            if (load_from_wr) head_q <= bus.wr_data;
            else if (ram_rd)  head_q <= ram[rd_ptr];
        end
    end

    // NOTE: the storage array has no reset; count and state alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (ram_wr) ram[wr_ptr] <= bus.wr_data;
    end

    assign bus.rd_data      = head_q;
    assign bus.rd_vld       = (state_q == S_VALID);
    assign bus.count        = count_q;
    assign bus.wr_vld       = wr_vld_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

`ifdef FIFO_ERR_STATS_EN
    logic ovf_q, udf_q;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr_en && !wr_vld_q)          ovf_q <= 1'b1;
            else if (bus.err_clr || bus.flush)   ovf_q <= 1'b0;
            if (bus.rd_en && state_q != S_VALID) udf_q <= 1'b1;
            else if (bus.err_clr || bus.flush)   udf_q <= 1'b0;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`endif
endmodule
